poly_solver: RTL
================

Name: poly_solver

Overview:
- Parametrised successor of the fixed quadratic expression solver.
- Evaluates a signed polynomial of configurable degree, result = sum of C[i]*X^i for i = 0..DEG.
- Uses Horner's method: one multiply-add step per clock.
- Keeps the start/completed handshake and zero/overflow flags; sits as a multi-cycle arithmetic unit behind a host FSM.

Parameters:
- XW, 8, width of signed input X.
- CW, 16, width of each signed coefficient.
- RW, 16, width of signed result and accumulator.
- DEG, 2, polynomial degree (>= 0).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- X  input  XW  signed evaluation point.
- COEF  input  (DEG+1)*CW  packed signed coefficients; C[i] = COEF[i*CW +: CW], the coefficient of X^i.
- result  output  RW  signed polynomial value.
- zero  output  1  result == 0.
- overflow  output  1  sticky range violation during the evaluation.
- busy  output  1  evaluation in progress (RUN or DONE).
- completed  output  1  one-cycle pulse, result valid.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; result=0, zero=0, overflow=0, busy=0, completed=0; internal X/coef registers and step counter cleared.
- Reset mid-operation aborts the evaluation; no completed pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: latch X and COEF; acc <= sign-extended C[DEG]; cnt <= DEG-1; overflow <= 0; go to RUN.
  - If DEG==0: go directly to DONE instead of RUN.
  - If C[DEG] does not fit RW, overflow is set at load.
- RUN, each cycle:
  - full = acc*X + C[cnt], computed at RW+XW+1 bits, signed.
  - If full lies outside [-2^(RW-1), 2^(RW-1)-1]: overflow <= 1 (sticky).
  - acc <= full truncated to RW bits (two's complement wrap).
  - If cnt==0, go to DONE; else cnt decrements.
- DONE: completed=1 for exactly one cycle; then IDLE.
- Latency: start sampled at edge t gives completed high during cycle t+DEG+1.
- result, zero and overflow update on entry to DONE and hold until the next accepted start.
- zero = (result == 0), evaluated on the final value.
- busy=1 in RUN and DONE.
- start while busy (RUN or DONE) is ignored; no queuing.
- X/COEF changes after the start cycle have no effect on the running evaluation.

Optional Feature:
- Macro: POLY_SOLVER_SATURATE_EN.
- When defined: each step clamps full to 2^(RW-1)-1 or -2^(RW-1) instead of wrapping; overflow is still set.
- When undefined: wrap behaviour as above. Latency is identical either way.

Decomposition:
- Package poly_solver_pkg holds:
  - the state encoding constants IDLE/RUN/DONE;
  - a width helper constant PROD_W = RW+XW+1;
  - the counter width function clog2(DEG+1).
- One natural sub-module, poly_operative: X/coef/acc registers, Horner multiply-add, range check, wrap/saturate, zero/overflow flags.
- The FSM and counter stay in poly_solver, mirroring the control/operative split.

Test Plan:
- DEG=2, X=3, C2=2, C1=-5, C0=7, start pulse -> completed exactly 3 cycles after start edge, result=10, zero=0, overflow=0, busy high 3 cycles.
- X=-2, C2=1, C1=0, C0=0 -> result=4; then X=1, C2=1, C1=-2, C0=1 -> result=0, zero=1.
- X=127, C2=16000, C1=0, C0=0, macro off -> overflow=1, result=-16768 (step1 wraps to 384, step2 48768 wraps); macro on -> overflow=1, result=32767.
- start held high during RUN and DONE with different X -> first evaluation unaffected, single completed pulse; the new start is accepted only in IDLE and gives a second result.
- rst low during RUN -> outputs 0 immediately (asynchronous), no completed pulse; fresh start after release gives the correct result.
- DEG=0 build, C0=-5 -> completed 1 cycle after start, result=-5; DEG=4 build, X=2, all C=1 -> result=31, latency 5.

Source files
------------

// File: rtl/poly_solver_pkg.sv
// Shared types and width helpers for the Horner polynomial evaluator.
package poly_solver_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Step counter width; never below one bit so DEG==0 still has a legal vector.
  function automatic int cnt_w(input int deg);
    int r;
    r = clog2(deg + 1);
    return (r < 1) ? 1 : r;
  endfunction

  // Width at which one multiply-add step is evaluated.
  function automatic int prod_w(input int rw, input int xw);
    return rw + xw + 1;
  endfunction

endpackage

// File: rtl/poly_operative.sv
// Datapath: operand/accumulator registers, Horner multiply-add, range check and flags.
// Clamping instead of wrapping is selected by POLY_SOLVER_SATURATE_EN.
module poly_operative
  import poly_solver_pkg::*;
#(
  parameter int XW   = 8,
  parameter int CW   = 16,
  parameter int RW   = 16,
  parameter int DEG  = 2,
  parameter int CNTW = 2
) (
  input  logic                    clk,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    step_i,
  input  logic                    finish_i,
  input  logic [CNTW-1:0]         sel_i,
  input  logic signed [XW-1:0]    x_i,
  input  logic [(DEG+1)*CW-1:0]   coef_i,
  output logic signed [RW-1:0]    result_o,
  output logic                    zero_o,
  output logic                    overflow_o
);

  localparam int PROD_W = prod_w(RW, XW);
  // Wide enough for the step sum and for a coefficient wider than the accumulator.
  localparam int EW = (CW + 1 > PROD_W) ? CW + 1 : PROD_W;

  logic signed [XW-1:0]       x_q, x_d;
  logic [(DEG+1)*CW-1:0]      coef_q, coef_d;
  logic signed [RW-1:0]       acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic signed [RW-1:0]       res_q;
  logic                       zero_q, ovf_out_q;

  logic signed [CW-1:0]       lead_c_s, step_c_s;
  logic signed [EW-1:0]       lead_w_s, full_w_s;

  function automatic logic in_range(input logic signed [EW-1:0] v);
    return (&v[EW-1:RW-1]) | ~(|v[EW-1:RW-1]);
  endfunction

  function automatic logic [RW-1:0] fit(input logic signed [EW-1:0] v);
    logic [RW-1:0] r;
`ifdef POLY_SOLVER_SATURATE_EN
    if (in_range(v)) r = v[RW-1:0];
    else if (v[EW-1]) r = {1'b1, {(RW-1){1'b0}}};
    else r = {1'b0, {(RW-1){1'b1}}};
`else
    r = v[RW-1:0];
`endif
    return r;
  endfunction

  assign lead_c_s = coef_i[DEG*CW +: CW];
  assign step_c_s = coef_q[sel_i*CW +: CW];
  assign lead_w_s = EW'(lead_c_s);
  assign full_w_s = EW'(acc_q) * EW'(x_q) + EW'(step_c_s);

  // Next-state for operands, accumulator and sticky overflow.
  always_comb begin
    x_d    = x_q;
    coef_d = coef_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    if (load_i) begin
      x_d    = x_i;
      coef_d = coef_i;
      acc_d  = fit(lead_w_s);
      ovf_d  = ~in_range(lead_w_s);
    end else if (step_i) begin
      acc_d  = fit(full_w_s);
      ovf_d  = ovf_q | ~in_range(full_w_s);
    end else begin
      acc_d  = acc_q;
    end
  end

  // Visible result and flags only change when an evaluation finishes.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q       <= '0;
      coef_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_out_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      coef_q <= coef_d;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      if (finish_i) begin
        res_q     <= acc_d;
        zero_q    <= (acc_d == {RW{1'b0}});
        ovf_out_q <= ovf_d;
      end else begin
        res_q     <= res_q;
      end
    end
  end

  assign result_o   = res_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_out_q;

endmodule

// File: rtl/poly_solver.sv
// Multi-cycle signed polynomial evaluator (Horner, one step per clock) with start/completed handshake.
// Optional clamping of each step via POLY_SOLVER_SATURATE_EN (default: two's complement wrap).
module poly_solver
  import poly_solver_pkg::*;
#(
  parameter int XW  = 8,
  parameter int CW  = 16,
  parameter int RW  = 16,
  parameter int DEG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [XW-1:0]    X,
  input  logic [(DEG+1)*CW-1:0]   COEF,
  output logic signed [RW-1:0]    result,
  output logic                    zero,
  output logic                    overflow,
  output logic                    busy,
  output logic                    completed
);

  localparam int CNTW = cnt_w(DEG);
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'((DEG > 0) ? DEG - 1 : 0);

  state_e          state_q;
  logic [CNTW-1:0] cnt_q;
  logic            busy_q, completed_q;
  logic            load_s, step_s, finish_s;

  assign load_s   = (state_q == IDLE) && start;
  assign step_s   = (state_q == RUN);
  assign finish_s = (load_s && (DEG == 0)) || (step_s && (cnt_q == {CNTW{1'b0}}));

  // Control FSM with step counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      completed_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q  <= CNT_INIT;
            busy_q <= 1'b1;
            if (DEG == 0) begin
              state_q     <= DONE;
              completed_q <= 1'b1;
            end else begin
              state_q     <= RUN;
              completed_q <= 1'b0;
            end
          end else begin
            busy_q      <= 1'b0;
            completed_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt_q == {CNTW{1'b0}}) begin
            state_q     <= DONE;
            completed_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - {{(CNTW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          completed_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          cnt_q       <= '0;
          busy_q      <= 1'b0;
          completed_q <= 1'b0;
        end
      endcase
    end
  end

  poly_operative #(
    .XW  (XW),
    .CW  (CW),
    .RW  (RW),
    .DEG (DEG),
    .CNTW(CNTW)
  ) u_operative (
    .clk       (clk),
    .rst_ni    (rst),
    .load_i    (load_s),
    .step_i    (step_s),
    .finish_i  (finish_s),
    .sel_i     (cnt_q),
    .x_i       (X),
    .coef_i    (COEF),
    .result_o  (result),
    .zero_o    (zero),
    .overflow_o(overflow)
  );

  assign busy      = busy_q;
  assign completed = completed_q;

endmodule
